bus_vector_mem_slave: RTL and testbench

OCP-style bus responder that terminates the word-addressed `Bus_if` port driven by the vector load/store unit (or any other bus master) and backs it with an on-chip word memory. It accepts pipelined read and write commands, performs byte-enabled writes and registered reads, and returns one in-order response per accepted command through a response FIFO. The FIFO absorbs master backpressure on `MRespAccept`. It sits on the far side of the vector unit's bus, standing in as local vector-data memory.

---
 rtl/bus_vector_mem_slave_if.sv | 40 ++++
 rtl/bus_vector_mem_slave.sv | 152 +++++++++++++++
 tb/tb_bus_vector_mem_slave.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_vector_mem_slave_if.sv
// Bus command/response definitions and the Bus_if port bundle.
//
// Package Bus : MCmd encodings (IDLE/WR/RD), SResp encodings (NULL/DVA/ERR)
//               and the Word address type.
// Bus_if      : OCP-style word-addressed bus.
//   master -> slave : MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n
//   slave -> master : SCmdAccept, SResp, SData
package Bus;
  typedef logic [31:0] Word;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;

  localparam logic [1:0] NULL = 2'd0;
  localparam logic [1:0] DVA  = 2'd1;
  localparam logic [1:0] ERR  = 2'd3;
endpackage

interface Bus_if;
  logic [2:0]  MCmd;
  Bus::Word    MAddr;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic        MRespAccept;
  logic        MReset_n;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [31:0] SData;

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
    output SCmdAccept, SResp, SData
  );
endinterface

// File: rtl/bus_vector_mem_slave.sv
// Bus responder backed by an on-chip word memory.
//
// Accepts one RD/WR command per cycle, performs byte-enabled writes and
// registered reads, and returns one in-order response per accepted command
// through a one-entry pipeline stage feeding a response FIFO.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (clears FIFO/stage, not memory)
//   bus   : Bus_if.slave (MReset_n acts as a synchronous soft reset)
module bus_vector_mem_slave #(
  parameter int MEM_DEPTH       = 1024,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  Bus_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(RESP_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RESP_FIFO_DEPTH);

  logic [31:0]   mem_r [MEM_DEPTH];
  logic [31:0]   rd_data_r;

  logic          stage_valid_r;
  logic [1:0]    stage_resp_r;
  logic          stage_rd_r;
  logic [31:0]   stage_data_s;

  logic [1:0]    fifo_resp_r [RESP_FIFO_DEPTH];
  logic [31:0]   fifo_data_r [RESP_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          cmd_valid_s;
  logic          in_range_s;
  logic          cmd_accept_s;
  logic          accept_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic          push_s;
  logic          pop_s;
  logic [CW:0]   credits_s;
  logic [AW-1:0] mem_addr_s;

  // Command decode and credit-based accept. The stage entry counts as a
  // credit so that its unconditional push always finds room in the FIFO.
  always_comb begin
    cmd_valid_s  = (bus.MCmd == Bus::WR) || (bus.MCmd == Bus::RD);
    in_range_s   = (bus.MAddr[31:AW] == {(32 - AW){1'b0}});
    mem_addr_s   = bus.MAddr[AW-1:0];
    credits_s    = {1'b0, count_r} + {{CW{1'b0}}, stage_valid_r};
    cmd_accept_s = (credits_s < DEPTH_C) && bus.MReset_n && !reset;
    accept_s     = cmd_valid_s && cmd_accept_s;
    wr_en_s      = accept_s && (bus.MCmd == Bus::WR) && in_range_s;
    rd_en_s      = accept_s && (bus.MCmd == Bus::RD) && in_range_s;
    push_s       = stage_valid_r;
    pop_s        = (count_r != {CW{1'b0}}) && bus.MRespAccept;
  end

  // Memory array: byte-enabled write and registered read (no reset, contents
  // survive both reset flavours).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.MByteEn[b]) begin
          mem_r[mem_addr_s][8*b +: 8] <= bus.MData[8*b +: 8];
        end
      end
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[mem_addr_s];
    end
  end

  // Stage data: reads return the registered memory word, everything else 0.
  always_comb begin
    if (stage_rd_r) begin
      stage_data_s = rd_data_r;
    end else begin
      stage_data_s = 32'h0000_0000;
    end
  end

  // Pipeline stage, FIFO pointers and occupancy with async and soft reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_r <= 1'b0;
      stage_resp_r  <= Bus::NULL;
      stage_rd_r    <= 1'b0;
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (!bus.MReset_n) begin
      stage_valid_r <= 1'b0;
      stage_resp_r  <= Bus::NULL;
      stage_rd_r    <= 1'b0;
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        stage_resp_r <= in_range_s ? Bus::DVA : Bus::ERR;
        stage_rd_r   <= rd_en_s;
      end else begin
        stage_resp_r <= stage_resp_r;
        stage_rd_r   <= stage_rd_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_resp_r[wr_ptr_r] <= stage_resp_r;
      fifo_data_r[wr_ptr_r] <= stage_data_s;
    end
  end

  // Response outputs come straight from the FIFO head register.
  always_comb begin
    bus.SCmdAccept = cmd_accept_s;
    if (count_r != {CW{1'b0}}) begin
      bus.SResp = fifo_resp_r[rd_ptr_r];
      bus.SData = fifo_data_r[rd_ptr_r];
    end else begin
      bus.SResp = Bus::NULL;
      bus.SData = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_bus_vector_mem_slave.sv
// Self-checking bench for bus_vector_mem_slave: directed vector table,
// scoreboard of expected responses, and hand-written corner sequences.
module tb_bus_vector_mem_slave;

  logic clk;
  logic reset;
  Bus_if bus_i();

  bus_vector_mem_slave #(.MEM_DEPTH(1024), .RESP_FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[10];
  logic [33:0] sb[$];
  logic [1:0]  pend_resp;
  logic [31:0] pend_data;
  logic        acc;
  logic        rand_ra;
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] wvals[16];
  logic [31:0] rvals[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // One clock: at negedge compare head vs scoreboard, record accepts; return at posedge+1.
  task automatic cycle();
    if (rand_ra) bus_i.MRespAccept = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (bus_i.SResp != Bus::NULL) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {30'd0, bus_i.SResp, bus_i.SData}, 64'd0);
      end else begin
        chk("resp_head", {30'd0, bus_i.SResp, bus_i.SData}, {30'd0, sb[0]});
        if (bus_i.MRespAccept) void'(sb.pop_front());
      end
    end
    acc = 1'b0;
    if (((bus_i.MCmd == Bus::WR) || (bus_i.MCmd == Bus::RD)) && bus_i.SCmdAccept) begin
      acc = 1'b1;
      sb.push_back({pend_resp, pend_data});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [1:0] er, input logic [31:0] ed);
    bus_i.MCmd    = cmd;
    bus_i.MAddr   = addr;
    bus_i.MData   = data;
    bus_i.MByteEn = be;
    pend_resp     = er;
    pend_data     = ed;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (acc) return;
    end
    fail_now("issue_timeout");
  endtask

  task automatic drain();
    bus_i.MCmd        = Bus::IDLE;
    bus_i.MRespAccept = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) return;
      cycle();
    end
    fail_now("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int c0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rand_ra = 1'b0;

    vecs[0] = '{Bus::WR, 32'd0,          32'h0102_0304, 4'hF, Bus::DVA, 32'h0};
    vecs[1] = '{Bus::WR, 32'd5,          32'hDEAD_BEEF, 4'hF, Bus::DVA, 32'h0};
    vecs[2] = '{Bus::RD, 32'd5,          32'h0,         4'hF, Bus::DVA, 32'hDEAD_BEEF};
    vecs[3] = '{Bus::WR, 32'd7,          32'h1122_3344, 4'hF, Bus::DVA, 32'h0};
    vecs[4] = '{Bus::WR, 32'd7,          32'hAABB_CCDD, 4'h5, Bus::DVA, 32'h0};
    vecs[5] = '{Bus::RD, 32'd7,          32'h0,         4'hF, Bus::DVA, 32'h11BB_33DD};
    vecs[6] = '{Bus::RD, 32'd1024,       32'h0,         4'hF, Bus::ERR, 32'h0};
    vecs[7] = '{Bus::WR, 32'd1024,       32'hFFFF_FFFF, 4'hF, Bus::ERR, 32'h0};
    vecs[8] = '{Bus::RD, 32'd0,          32'h0,         4'hF, Bus::DVA, 32'h0102_0304};
    vecs[9] = '{Bus::RD, 32'h8000_0000,  32'h0,         4'hF, Bus::ERR, 32'h0};

    // Reset state
    bus_i.MCmd        = Bus::IDLE;
    bus_i.MAddr       = 32'h0;
    bus_i.MData       = 32'h0;
    bus_i.MByteEn     = 4'h0;
    bus_i.MRespAccept = 1'b0;
    bus_i.MReset_n    = 1'b1;
    reset             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdaccept", {63'd0, bus_i.SCmdAccept}, 64'd0);
    chk("rst_sresp", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});
    chk("rst_sdata", {32'd0, bus_i.SData}, 64'd0);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmdaccept", {63'd0, bus_i.SCmdAccept}, 64'd1);

    // Latency: accept edge k -> response visible in cycle k+2
    bus_i.MRespAccept = 1'b1;
    bus_i.MCmd = Bus::WR; bus_i.MAddr = 32'd9; bus_i.MData = 32'h1234_5678; bus_i.MByteEn = 4'hF;
    pend_resp = Bus::DVA; pend_data = 32'h0;
    cycle();
    chk("lat_accept", {63'd0, acc}, 64'd1);
    bus_i.MCmd = Bus::IDLE;
    chk("lat_k1_null", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});
    cycle();
    chk("lat_k2_dva", {30'd0, bus_i.SResp, bus_i.SData}, {30'd0, Bus::DVA, 32'h0});
    drain();

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_resp, vecs[i].exp_data);
      drain();
    end

    // Burst of 16 writes, back to back, no stalls expected
    bus_i.MRespAccept = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      wvals[i] = $urandom;
      issue(Bus::WR, 32'h40 + 32'(i), wvals[i], 4'hF, Bus::DVA, 32'h0);
    end
    chk("burst_wr_cycles", 64'(cyc - c0), 64'd16);
    // 16 reads with random response acceptance
    rand_ra = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(Bus::RD, 32'h40 + 32'(i), 32'h0, 4'hF, Bus::DVA, wvals[i]);
    end
    rand_ra = 1'b0;
    drain();

    // Backpressure: 8 reads with MRespAccept low, only 4 may be accepted
    bus_i.MRespAccept = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus_i.MCmd = Bus::RD; bus_i.MAddr = 32'h40 + 32'(n_acc);
      pend_resp = Bus::DVA; pend_data = wvals[n_acc];
      cycle();
      if (acc) n_acc++;
    end
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_cmdaccept_low", {63'd0, bus_i.SCmdAccept}, 64'd0);
    bus_i.MCmd = Bus::IDLE;
    bus_i.MRespAccept = 1'b1;
    #1;
    chk("bp_no_comb_release", {63'd0, bus_i.SCmdAccept}, 64'd0);
    cycle();
    chk("bp_release", {63'd0, bus_i.SCmdAccept}, 64'd1);
    while (n_acc < 8) begin
      issue(Bus::RD, 32'h40 + 32'(n_acc), 32'h0, 4'hF, Bus::DVA, wvals[n_acc]);
      n_acc++;
    end
    drain();

    // Soft reset with two responses pending
    bus_i.MRespAccept = 1'b0;
    issue(Bus::RD, 32'h40, 32'h0, 4'hF, Bus::DVA, wvals[0]);
    issue(Bus::RD, 32'h41, 32'h0, 4'hF, Bus::DVA, wvals[1]);
    bus_i.MCmd = Bus::IDLE;
    cycle();
    bus_i.MReset_n = 1'b0;
    #1;
    chk("srst_cmdaccept", {63'd0, bus_i.SCmdAccept}, 64'd0);
    @(posedge clk);
    #1;
    bus_i.MReset_n = 1'b1;
    sb.delete();
    chk("srst_sresp", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});

    // Async reset mid-burst with 3 write responses pending
    for (int i = 0; i < 3; i++) begin
      rvals[i] = $urandom;
      issue(Bus::WR, 32'h50 + 32'(i), rvals[i], 4'hF, Bus::DVA, 32'h0);
    end
    bus_i.MCmd = Bus::IDLE;
    cycle();
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("arst_sresp", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});
    chk("arst_cmdaccept", {63'd0, bus_i.SCmdAccept}, 64'd0);
    sb.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_release_accept", {63'd0, bus_i.SCmdAccept}, 64'd1);
    chk("arst_no_stale", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});
    bus_i.MRespAccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(Bus::RD, 32'h50 + 32'(i), 32'h0, 4'hF, Bus::DVA, rvals[i]);
    end
    issue(Bus::RD, 32'd7, 32'h0, 4'hF, Bus::DVA, 32'h11BB_33DD);
    drain();
    repeat (3) cycle();
    chk("final_idle", {62'd0, bus_i.SResp}, {62'd0, Bus::NULL});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
